nsc8_control_sequencer: RTL and testbench

- Control unit for the NSC-8 8-bit datapath: program counter, MAR, RAM, IR, A/B registers, ALU, flags, output register.
- Owns the T-state ring counter and decodes the IR opcode into a 16-bit control word per T-state.
- Sequences fetch (T0–T2) and execute (T3–T5), supports single-step gating and halt.
- Sits between the IR/flags and every datapath load/enable line, replacing the separate ring counter.

---
 rtl/nsc8_control_sequencer.sv | 165 ++++++++++++++++
 tb/tb_nsc8_control_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nsc8_control_sequencer.sv
// NSC-8 control sequencer: T-state ring counter plus opcode decode into the
// 16-bit datapath control word. The fetch cycle is T0..T2 and the execute
// cycle is T3..T5. HLT latches a halted flag that freezes the ring at T3.
// Optional build macro NSC8_VARCYCLE_EN: when it is defined, each instruction
// returns to T0 right after its last non-zero execute state. When it is left
// undefined, every instruction uses all six T-states.
module nsc8_control_sequencer #(
    parameter int NUM_T = 6,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_en,
    input  logic [3:0]       opcode,
    input  logic             zero_flag,
    input  logic             carry_flag,
    output logic [CW-1:0]    ctrl_word,
    output logic [NUM_T-1:0] t_state,
    output logic             halted
);

    // One-hot T-states; the enum encoding is the ring itself
    typedef enum logic [5:0] {
        T0 = 6'b000001,
        T1 = 6'b000010,
        T2 = 6'b000100,
        T3 = 6'b001000,
        T4 = 6'b010000,
        T5 = 6'b100000
    } t_state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JZ  = 4'h7,
        OP_JC  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Control line positions within the control word
    localparam logic [15:0] PC_INC     = 16'h0001;
    localparam logic [15:0] PC_OUT     = 16'h0002;
    localparam logic [15:0] PC_LOAD    = 16'h0004;
    localparam logic [15:0] MAR_LOAD   = 16'h0008;
    localparam logic [15:0] RAM_OUT    = 16'h0010;
    localparam logic [15:0] RAM_LOAD   = 16'h0020;
    localparam logic [15:0] IR_LOAD    = 16'h0040;
    localparam logic [15:0] IR_OUT     = 16'h0080;
    localparam logic [15:0] A_LOAD     = 16'h0100;
    localparam logic [15:0] A_OUT      = 16'h0200;
    localparam logic [15:0] ALU_OUT    = 16'h0400;
    localparam logic [15:0] ALU_SUB    = 16'h0800;
    localparam logic [15:0] B_LOAD     = 16'h1000;
    localparam logic [15:0] OUT_LOAD   = 16'h2000;
    localparam logic [15:0] FLAGS_LOAD = 16'h4000;
    localparam logic [15:0] HALT       = 16'h8000;

    t_state_e    state;
    t_state_e    state_next;
    logic        halted_next;
    logic        ends_here;
    logic [15:0] decoded;
    opcode_e     op;

    assign op      = opcode_e'(opcode);
    assign t_state = state;

    // Ring and halt register; reset aborts any instruction and restarts at T0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= T0;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
        end
    end

    // Mark the T-state that is the last one of the current instruction
    always_comb begin
        ends_here = 1'b0;
`ifdef NSC8_VARCYCLE_EN
        unique case (state)
            T3: ends_here = !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_HLT});
            T4: ends_here = (op == OP_LDA) || (op == OP_STA);
            T5: ends_here = 1'b1;
            default: ends_here = 1'b0;
        endcase
`else
        ends_here = (state == T5);
`endif
    end

    // Next ring position and halt latch; the ring is frozen while halted
    always_comb begin
        state_next  = state;
        halted_next = halted;
        if (step_en && !halted) begin
            if (state == T3 && op == OP_HLT) begin
                halted_next = 1'b1;
            end else if (ends_here) begin
                state_next = T0;
            end else begin
                state_next = t_state_e'({state[4:0], state[5]});
            end
        end
    end

    // Moore decode of the control word from the T-state, opcode and flags
    always_comb begin
        decoded = 16'h0000;
        unique case (state)
            T0: decoded = PC_OUT | MAR_LOAD;
            T1: decoded = PC_INC;
            T2: decoded = RAM_OUT | IR_LOAD;
            T3: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: decoded = IR_OUT | MAR_LOAD;
                    OP_LDI: decoded = IR_OUT | A_LOAD;
                    OP_JMP: decoded = IR_OUT | PC_LOAD;
                    OP_JZ:  decoded = zero_flag  ? (IR_OUT | PC_LOAD) : 16'h0000;
                    OP_JC:  decoded = carry_flag ? (IR_OUT | PC_LOAD) : 16'h0000;
                    OP_OUT: decoded = A_OUT | OUT_LOAD;
                    OP_HLT: decoded = HALT;
                    default: decoded = 16'h0000;
                endcase
            end
            T4: begin
                case (op)
                    OP_LDA:         decoded = RAM_OUT | A_LOAD;
                    OP_ADD, OP_SUB: decoded = RAM_OUT | B_LOAD;
                    OP_STA:         decoded = A_OUT | RAM_LOAD;
                    default:        decoded = 16'h0000;
                endcase
            end
            T5: begin
                case (op)
                    OP_ADD:  decoded = ALU_OUT | A_LOAD | FLAGS_LOAD;
                    OP_SUB:  decoded = ALU_OUT | ALU_SUB | A_LOAD | FLAGS_LOAD;
                    default: decoded = 16'h0000;
                endcase
            end
            default: decoded = 16'h0000;
        endcase
    end

    // Output gating: reset blanks, halt overrides step gating, step low blanks
    always_comb begin
        ctrl_word = '0;
        if (!reset_n) begin
            ctrl_word = '0;
        end else if (halted) begin
            ctrl_word = CW'(HALT);
        end else if (step_en) begin
            ctrl_word = CW'(decoded);
        end
    end

endmodule

// File: tb/tb_nsc8_control_sequencer.sv
// Self-checking bench for nsc8_control_sequencer. Expected control words,
// ring positions and halt state go into a scoreboard queue. They are popped
// and compared on the falling edge of each cycle.
module tb_nsc8_control_sequencer;

    logic        clk;
    logic        reset_n;
    logic        step_en;
    logic [3:0]  opcode;
    logic        zero_flag;
    logic        carry_flag;
    logic [15:0] ctrl_word;
    logic [5:0]  t_state;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        step;
        logic [15:0] cw;
        logic [5:0]  ts;
        logic        hlt;
        string       tag;
    } exp_t;

    exp_t sb[$];

    nsc8_control_sequencer #(.NUM_T(6), .CW(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .step_en    (step_en),
        .opcode     (opcode),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .ctrl_word  (ctrl_word),
        .t_state    (t_state),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for T-state t under the given opcode and flags
    function automatic logic [15:0] exp_cw(int t, logic [3:0] op, logic z, logic c);
        exp_cw = 16'h0000;
        case (t)
            0: exp_cw = 16'h000A;
            1: exp_cw = 16'h0001;
            2: exp_cw = 16'h0050;
            3: case (op)
                   4'h1, 4'h2, 4'h3, 4'h4: exp_cw = 16'h0088;
                   4'h5: exp_cw = 16'h0180;
                   4'h6: exp_cw = 16'h0084;
                   4'h7: exp_cw = z ? 16'h0084 : 16'h0000;
                   4'h8: exp_cw = c ? 16'h0084 : 16'h0000;
                   4'hE: exp_cw = 16'h2200;
                   4'hF: exp_cw = 16'h8000;
                   default: exp_cw = 16'h0000;
               endcase
            4: case (op)
                   4'h1: exp_cw = 16'h0110;
                   4'h2, 4'h3: exp_cw = 16'h1010;
                   4'h4: exp_cw = 16'h0220;
                   default: exp_cw = 16'h0000;
               endcase
            5: case (op)
                   4'h2: exp_cw = 16'h4500;
                   4'h3: exp_cw = 16'h4D00;
                   default: exp_cw = 16'h0000;
               endcase
            default: exp_cw = 16'h0000;
        endcase
    endfunction

    // Number of T-states an instruction occupies before the ring returns to T0
    function automatic int exp_len(logic [3:0] op);
`ifdef NSC8_VARCYCLE_EN
        case (op)
            4'h1, 4'h4: exp_len = 5;
            4'h2, 4'h3: exp_len = 6;
            default:    exp_len = 4;
        endcase
`else
        exp_len = 6;
        if (op == 4'hF) exp_len = 6;
`endif
    endfunction

    task automatic push(logic step, logic [15:0] cw, logic [5:0] ts, logic hlt, string tag);
        exp_t e;
        e.step = step;
        e.cw   = cw;
        e.ts   = ts;
        e.hlt  = hlt;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Pop one scoreboard entry and compare it against the DUT outputs
    task automatic checkOutput();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (ctrl_word === e.cw) else begin
            errors++;
            $error("[TB] FAIL %s ctrl_word observed %h expected %h", e.tag, ctrl_word, e.cw);
        end
        checks++;
        assert (t_state === e.ts) else begin
            errors++;
            $error("[TB] FAIL %s t_state observed %b expected %b", e.tag, t_state, e.ts);
        end
        checks++;
        assert (halted === e.hlt) else begin
            errors++;
            $error("[TB] FAIL %s halted observed %b expected %b", e.tag, halted, e.hlt);
        end
    endtask

    // Consume the scoreboard one clock at a time, applying each entry's step_en
    task automatic runQueue();
        while (sb.size() > 0) begin
            step_en = sb[0].step;
            @(negedge clk);
            checkOutput();
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the expected cycles of one instruction, optionally stalling in one T-state
    task automatic applyStimulus(logic [3:0] op, logic z, logic c, int n_cycles,
                                 int stall_at, int stall_len, string tag);
        opcode     = op;
        zero_flag  = z;
        carry_flag = c;
        for (int t = 0; t < n_cycles; t++) begin
            if (t == stall_at) begin
                for (int s = 0; s < stall_len; s++)
                    push(1'b0, 16'h0000, 6'(1 << t), 1'b0, {tag, "_stall"});
            end
            push(1'b1, exp_cw(t, op, z, c), 6'(1 << t), 1'b0, $sformatf("%s_T%0d", tag, t));
        end
        runQueue();
    endtask

    // Assert reset for one cycle, check the reset state, then release it
    task automatic doReset(string tag);
        reset_n = 1'b0;
        step_en = 1'b1;
        push(1'b1, 16'h0000, 6'b000001, 1'b0, tag);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        step_en    = 1'b1;
        opcode     = 4'h0;
        zero_flag  = 1'b0;
        carry_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        doReset("reset");

        applyStimulus(4'h1, 1'b0, 1'b0, exp_len(4'h1), 4, 5, "lda");
        applyStimulus(4'h2, 1'b0, 1'b0, exp_len(4'h2), -1, 0, "add");
        applyStimulus(4'h3, 1'b0, 1'b0, exp_len(4'h3), -1, 0, "sub");
        applyStimulus(4'h4, 1'b0, 1'b0, exp_len(4'h4), -1, 0, "sta");
        applyStimulus(4'h5, 1'b0, 1'b0, exp_len(4'h5), -1, 0, "ldi");
        applyStimulus(4'h6, 1'b0, 1'b0, exp_len(4'h6), -1, 0, "jmp");
        applyStimulus(4'h7, 1'b1, 1'b0, exp_len(4'h7), -1, 0, "jz_taken");
        applyStimulus(4'h7, 1'b0, 1'b1, exp_len(4'h7), -1, 0, "jz_not");
        applyStimulus(4'h8, 1'b0, 1'b1, exp_len(4'h8), -1, 0, "jc_taken");
        applyStimulus(4'h8, 1'b1, 1'b0, exp_len(4'h8), -1, 0, "jc_not");
        applyStimulus(4'hE, 1'b0, 1'b0, exp_len(4'hE), -1, 0, "out");
        applyStimulus(4'h0, 1'b0, 1'b0, exp_len(4'h0), -1, 0, "nop");
        applyStimulus(4'hB, 1'b1, 1'b1, exp_len(4'hB), -1, 0, "op_b");

        // Reset in the middle of an ADD, then confirm a clean fetch from T0
        applyStimulus(4'h2, 1'b0, 1'b0, 5, -1, 0, "add_abort");
        doReset("reset_abort");
        applyStimulus(4'h5, 1'b0, 1'b0, exp_len(4'h5), -1, 0, "ldi_after_abort");

        // HLT: fetch and T3, then the ring stays frozen at T3 for 20 cycles
        applyStimulus(4'hF, 1'b0, 1'b0, 4, -1, 0, "hlt");
        opcode = 4'h2;
        for (int i = 0; i < 20; i++)
            push(1'b1, 16'h8000, 6'b001000, 1'b1, "halted");
        runQueue();
        doReset("reset_halt");
        applyStimulus(4'h0, 1'b0, 1'b0, exp_len(4'h0), -1, 0, "nop_after_halt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
